// File: rtl/mon_exp_seq_pkg.sv
// Shared op codes and state encodings for the Montgomery exponentiation sequencer.
package mon_pkg;

    localparam logic [1:0] OPXX = 2'd0;
    localparam logic [1:0] OPXM = 2'd1;
    localparam logic [1:0] OPX1 = 2'd2;
    localparam logic [1:0] OPXD = 2'd3;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] SCAN = 3'd1;
    localparam logic [2:0] SQR  = 3'd2;
    localparam logic [2:0] MUL  = 3'd3;
    localparam logic [2:0] CONV = 3'd4;
    localparam logic [2:0] FIN  = 3'd5;

endpackage

// File: rtl/mon_exp_seq_if.sv
// Handshake between the exponent sequencer (master) and the Montgomery product engine (slave).
interface mon_exp_seq_if;

    logic       mp_start;
    logic [1:0] mp_op;
    logic       mp_done;

    modport master (output mp_start, output mp_op, input mp_done);
    modport slave  (input mp_start, input mp_op, output mp_done);

endinterface

// File: rtl/mon_exp_seq.sv
// Left-to-right square-and-multiply sequencer driving an external Montgomery product engine.
// Optional constant-time schedule: define MON_EXP_CONST_TIME_EN.
module mon_exp_seq
    import mon_pkg::*;
#(
    parameter int EBITS = 256,
    parameter int IBITS = $clog2(EBITS),
    parameter int CBITS = $clog2(2*EBITS+2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [EBITS-1:0] e,
    output logic             busy,
    output logic             done,
    output logic             zero_exp,
    output logic [CBITS-1:0] prod_cnt,
    mon_exp_seq_if.master    mp
);

    logic [2:0]       state_q, state_d;
    logic [EBITS-1:0] e_q, e_d;
    logic [IBITS-1:0] idx_q, idx_d;
    logic [CBITS-1:0] cnt_q, cnt_d, cnt_inc;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             zero_q, zero_d;
    logic             mps_q, mps_d;
    logic [1:0]       op_q, op_d;
    logic             mpd_q;
    logic             rise;
    logic             bit_cur;
    logic             idx_zero;

`ifdef MON_EXP_CONST_TIME_EN
    logic             found_q, found_d;
    logic [IBITS-1:0] msb_q, msb_d;
    logic             scan_found;
    logic [IBITS-1:0] scan_msb;

    // Branch decision at idx 0 must include bit 0 itself, which is not yet recorded.
    assign scan_found = found_q | e_q[0];
    assign scan_msb   = found_q ? msb_q : '0;
`endif

    // An edge coinciding with our own launch pulse belongs to a stale op.
    assign rise     = mp.mp_done & ~mpd_q & ~mps_q;
    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CBITS'(1);
    assign bit_cur  = e_q[idx_q];
    assign idx_zero = (idx_q == '0);

    always_comb begin
        state_d = state_q;
        e_d     = e_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        zero_d  = zero_q;
        mps_d   = 1'b0;
        op_d    = op_q;
`ifdef MON_EXP_CONST_TIME_EN
        found_d = found_q;
        msb_d   = msb_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    e_d     = e;
                    idx_d   = IBITS'(EBITS-1);
                    cnt_d   = '0;
                    zero_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = SCAN;
`ifdef MON_EXP_CONST_TIME_EN
                    found_d = 1'b0;
                    msb_d   = '0;
`endif
                end
            end
            SCAN: begin
`ifdef MON_EXP_CONST_TIME_EN
                if (bit_cur && !found_q) begin
                    found_d = 1'b1;
                    msb_d   = idx_q;
                end
                if (!idx_zero) begin
                    idx_d = idx_q - IBITS'(1);
                end else if (!scan_found) begin
                    zero_d  = 1'b1;
                    state_d = FIN;
                end else if (scan_msb == '0) begin
                    mps_d   = 1'b1;
                    op_d    = OPX1;
                    cnt_d   = cnt_inc;
                    state_d = CONV;
                end else begin
                    idx_d   = scan_msb - IBITS'(1);
                    mps_d   = 1'b1;
                    op_d    = OPXX;
                    cnt_d   = cnt_inc;
                    state_d = SQR;
                end
`else
                if (bit_cur) begin
                    mps_d = 1'b1;
                    cnt_d = cnt_inc;
                    if (idx_zero) begin
                        op_d    = OPX1;
                        state_d = CONV;
                    end else begin
                        idx_d   = idx_q - IBITS'(1);
                        op_d    = OPXX;
                        state_d = SQR;
                    end
                end else if (idx_zero) begin
                    zero_d  = 1'b1;
                    state_d = FIN;
                end else begin
                    idx_d = idx_q - IBITS'(1);
                end
`endif
            end
            SQR: begin
                if (rise) begin
                    mps_d = 1'b1;
                    cnt_d = cnt_inc;
                    if (bit_cur) begin
                        op_d    = OPXM;
                        state_d = MUL;
`ifdef MON_EXP_CONST_TIME_EN
                    end else begin
                        op_d    = OPXD;
                        state_d = MUL;
                    end
`else
                    end else if (idx_zero) begin
                        op_d    = OPX1;
                        state_d = CONV;
                    end else begin
                        idx_d   = idx_q - IBITS'(1);
                        op_d    = OPXX;
                    end
`endif
                end
            end
            MUL: begin
                if (rise) begin
                    mps_d = 1'b1;
                    cnt_d = cnt_inc;
                    if (idx_zero) begin
                        op_d    = OPX1;
                        state_d = CONV;
                    end else begin
                        idx_d   = idx_q - IBITS'(1);
                        op_d    = OPXX;
                        state_d = SQR;
                    end
                end
            end
            CONV: begin
                if (rise) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            e_q     <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            zero_q  <= 1'b0;
            mps_q   <= 1'b0;
            op_q    <= OPXX;
            mpd_q   <= 1'b0;
`ifdef MON_EXP_CONST_TIME_EN
            found_q <= 1'b0;
            msb_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            e_q     <= e_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            zero_q  <= zero_d;
            mps_q   <= mps_d;
            op_q    <= op_d;
            mpd_q   <= mp.mp_done;
`ifdef MON_EXP_CONST_TIME_EN
            found_q <= found_d;
            msb_q   <= msb_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign zero_exp    = zero_q;
    assign prod_cnt    = cnt_q;
    assign mp.mp_start = mps_q;
    assign mp.mp_op    = op_q;

endmodule
